// File: rtl/burst_clk_pkg.sv
// Shared definitions for the burst clock generator.
// Holds the per-channel FSM state encoding and the synchronizer reset level.
// Synchronizers reset to 1 so an idle-high f0/c4 never produces a false fall.
package burst_clk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_TAIL  = 3'd4
  } state_t;

  localparam logic SYNC_RST = 1'b1;

endpackage

// File: rtl/burst_clk_chan.sv
// One burst clock channel: f0/c4 synchronizers, edge detect, burst FSM, counters.
// Ports: clk, rst_n (sync, active-low); f0/c4 async strobes; half_period,
//   tail_len, pulse_num config (latched on arm); clk_en, clk_out, done, retrig.
// Latency: strobe first sampled low at edge k acts at edge k+2; outputs registered.
module burst_clk_chan
  import burst_clk_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f0,
  input  logic              c4,
  input  logic [CNT_W-1:0]  half_period,
  input  logic [CNT_W-1:0]  tail_len,
  input  logic [PCNT_W-1:0] pulse_num,
  output logic              clk_en,
  output logic              clk_out,
  output logic              done,
  output logic              retrig
);

  state_t             state;
  logic               f0_s1, f0_s2, f0_prev;
  logic               c4_s1, c4_s2, c4_prev;
  logic [CNT_W-1:0]   phase_cnt;
  logic [PCNT_W-1:0]  pulse_cnt;
  logic [CNT_W-1:0]   h_lat;
  logic [CNT_W-1:0]   t_lat;
  logic [PCNT_W-1:0]  n_lat;

  logic f0_fall;
  logic c4_fall;
  logic tail_zero;

  assign f0_fall   = ~f0_s2 & f0_prev;
  assign c4_fall   = ~c4_s2 & c4_prev;
  assign tail_zero = (t_lat == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f0_s1     <= SYNC_RST;
      f0_s2     <= SYNC_RST;
      f0_prev   <= SYNC_RST;
      c4_s1     <= SYNC_RST;
      c4_s2     <= SYNC_RST;
      c4_prev   <= SYNC_RST;
      state     <= ST_IDLE;
      clk_en    <= 1'b0;
      clk_out   <= 1'b0;
      done      <= 1'b0;
      retrig    <= 1'b0;
      phase_cnt <= '0;
      pulse_cnt <= '0;
      h_lat     <= '0;
      t_lat     <= '0;
      n_lat     <= '0;
    end else begin
      f0_s1   <= f0;
      f0_s2   <= f0_s1;
      f0_prev <= f0_s2;
      c4_s1   <= c4;
      c4_s2   <= c4_s1;
      c4_prev <= c4_s2;

      done   <= 1'b0;
      retrig <= f0_fall && (state != ST_IDLE);

      // Phase counters load "length - 1" and the phase ends on the cycle the
      // counter reads zero, so a phase of length L occupies exactly L cycles.
      case (state)
        ST_IDLE: begin
          if (f0_fall) begin
            state  <= ST_ARMED;
            clk_en <= 1'b1;
            h_lat  <= (half_period == '0) ? CNT_W'(1) : half_period;
            t_lat  <= tail_len;
            n_lat  <= pulse_num;
          end
        end

        ST_ARMED: begin
          if (c4_fall) begin
            if (n_lat == '0) begin
              if (tail_zero) begin
                state  <= ST_IDLE;
                clk_en <= 1'b0;
                done   <= 1'b1;
              end else begin
                state     <= ST_TAIL;
                phase_cnt <= t_lat - CNT_W'(1);
              end
            end else begin
              state     <= ST_HIGH;
              clk_out   <= 1'b1;
              phase_cnt <= h_lat - CNT_W'(1);
              pulse_cnt <= PCNT_W'(1);
            end
          end
        end

        ST_HIGH: begin
          if (phase_cnt == '0) begin
            clk_out <= 1'b0;
            // The final high phase goes straight to the tail; the tail
            // stands in for the last low phase.
            if (pulse_cnt == n_lat) begin
              if (tail_zero) begin
                state  <= ST_IDLE;
                clk_en <= 1'b0;
                done   <= 1'b1;
              end else begin
                state     <= ST_TAIL;
                phase_cnt <= t_lat - CNT_W'(1);
              end
            end else begin
              state     <= ST_LOW;
              phase_cnt <= h_lat - CNT_W'(1);
            end
          end else begin
            phase_cnt <= phase_cnt - CNT_W'(1);
          end
        end

        ST_LOW: begin
          if (phase_cnt == '0) begin
            state     <= ST_HIGH;
            clk_out   <= 1'b1;
            phase_cnt <= h_lat - CNT_W'(1);
            pulse_cnt <= pulse_cnt + PCNT_W'(1);
          end else begin
            phase_cnt <= phase_cnt - CNT_W'(1);
          end
        end

        ST_TAIL: begin
          if (phase_cnt == '0) begin
            state  <= ST_IDLE;
            clk_en <= 1'b0;
            done   <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - CNT_W'(1);
          end
        end

        default: begin
          state   <= ST_IDLE;
          clk_en  <= 1'b0;
          clk_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/burst_clk_gen.sv
// Multi-channel burst clock generator; one independent burst_clk_chan per channel.
// Ports: clk, rst_n (sync, active-low); per-channel f0/c4 strobes and
//   clk_en/clk_out/done/retrig outputs; half_period/tail_len/pulse_num shared.
// Latency: see burst_clk_chan; no flow control, strobes are edge events.
module burst_clk_gen #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 16,
  parameter int PCNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] f0,
  input  logic [CHANNELS-1:0] c4,
  input  logic [CNT_W-1:0]    half_period,
  input  logic [CNT_W-1:0]    tail_len,
  input  logic [PCNT_W-1:0]   pulse_num,
  output logic [CHANNELS-1:0] clk_en,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] done,
  output logic [CHANNELS-1:0] retrig
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    burst_clk_chan #(
      .CNT_W  (CNT_W),
      .PCNT_W (PCNT_W)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .f0          (f0[i]),
      .c4          (c4[i]),
      .half_period (half_period),
      .tail_len    (tail_len),
      .pulse_num   (pulse_num),
      .clk_en      (clk_en[i]),
      .clk_out     (clk_out[i]),
      .done        (done[i]),
      .retrig      (retrig[i])
    );
  end

endmodule

// File: tb/tb_burst_clk_gen.sv
// Testbench for burst_clk_gen: event scoreboard fed by a timing-rule model.
// Stimulus pushes expected output events (kind, channel, cycle); a negedge
// monitor matches every observed output change against the scoreboard.
module tb_burst_clk_gen;

  localparam int CH     = 2;
  localparam int CNT_W  = 16;
  localparam int PCNT_W = 8;

  localparam int K_EN_RISE  = 0;
  localparam int K_EN_FALL  = 1;
  localparam int K_OUT_RISE = 2;
  localparam int K_OUT_FALL = 3;
  localparam int K_DONE     = 4;
  localparam int K_RETRIG   = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CH-1:0]     f0 = '1;
  logic [CH-1:0]     c4 = '1;
  logic [CNT_W-1:0]  half_period = '0;
  logic [CNT_W-1:0]  tail_len = '0;
  logic [PCNT_W-1:0] pulse_num = '0;
  logic [CH-1:0]     clk_en, clk_out, done, retrig;

  burst_clk_gen #(.CHANNELS(CH), .CNT_W(CNT_W), .PCNT_W(PCNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .f0(f0), .c4(c4),
    .half_period(half_period), .tail_len(tail_len), .pulse_num(pulse_num),
    .clk_en(clk_en), .clk_out(clk_out), .done(done), .retrig(retrig)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; read at negedges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int ch;
    int kind;
    int cyc;
  } ev_t;
  ev_t exq[$];

  // Reference model per channel: 0 idle, 1 armed, 2 running.
  int m_st[CH], m_arm[CH], m_e[CH], m_end[CH], m_h[CH], m_n[CH], m_t[CH];
  int f0_rel[CH], c4_rel[CH], f0_cool[CH], c4_cool[CH];
  int rise_cnt[CH], done_cnt[CH], retrig_cnt[CH];
  int first_rise[CH], en_fall_cyc[CH];
  bit in_burst[CH];
  int last_f0 = -100;
  bit mon_on = 1'b0;
  logic [CH-1:0] p_en = '0, p_out = '0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void push_ev(int ch, int kind, int c);
    ev_t ev;
    ev.ch = ch; ev.kind = kind; ev.cyc = c;
    exq.push_back(ev);
  endfunction

  // Stimulus driven at negedge m is first sampled at edge m+1 and acts at
  // edge m+3; the state it sees is the one held during cycle m+2.
  function automatic void model_refresh(int ch, int seen);
    if (m_st[ch] == 2 && seen >= m_end[ch]) m_st[ch] = 0;
  endfunction

  function automatic void model_f0(int ch, int m);
    model_refresh(ch, m + 2);
    if (m_st[ch] == 0) begin
      m_st[ch]  = 1;
      m_arm[ch] = m + 3;
      m_h[ch]   = (half_period == 0) ? 1 : int'(half_period);
      m_n[ch]   = int'(pulse_num);
      m_t[ch]   = int'(tail_len);
      push_ev(ch, K_EN_RISE, m + 3);
    end else begin
      push_ev(ch, K_RETRIG, m + 3);
    end
  endfunction

  function automatic void model_c4(int ch, int m);
    int e;
    model_refresh(ch, m + 2);
    if (m_st[ch] == 1 && m_arm[ch] <= m + 2) begin
      e = m + 3;
      m_st[ch] = 2;
      m_e[ch]  = e;
      if (m_n[ch] == 0) begin
        m_end[ch] = e + m_t[ch];
      end else begin
        for (int j = 0; j < m_n[ch]; j++) begin
          push_ev(ch, K_OUT_RISE, e + 2 * j * m_h[ch]);
          push_ev(ch, K_OUT_FALL, e + (2 * j + 1) * m_h[ch]);
        end
        m_end[ch] = e + (2 * m_n[ch] - 1) * m_h[ch] + m_t[ch];
      end
      push_ev(ch, K_EN_FALL, m_end[ch]);
      push_ev(ch, K_DONE, m_end[ch]);
    end
  endfunction

  // Reset driven at negedge m: every output reads 0 from cycle m+1 on.
  function automatic void model_reset(int m);
    bit en_lvl, out_lvl;
    for (int i = exq.size() - 1; i >= 0; i--)
      if (exq[i].cyc > m) exq.delete(i);
    for (int ch = 0; ch < CH; ch++) begin
      en_lvl  = (m_st[ch] == 1 && m_arm[ch] <= m) || (m_st[ch] == 2 && m < m_end[ch]);
      out_lvl = (m_st[ch] == 2) && (m_n[ch] > 0) && (m >= m_e[ch]) &&
                (m < m_e[ch] + (2 * m_n[ch] - 1) * m_h[ch]) &&
                (((m - m_e[ch]) / m_h[ch]) % 2 == 0);
      if (en_lvl)  push_ev(ch, K_EN_FALL, m + 1);
      if (out_lvl) push_ev(ch, K_OUT_FALL, m + 1);
      m_st[ch] = 0;
    end
  endfunction

  function automatic void match(int ch, int kind);
    bit found = 1'b0;
    n_checks++;
    for (int i = 0; i < exq.size(); i++) begin
      if (!found && exq[i].ch == ch && exq[i].kind == kind && exq[i].cyc == cyc) begin
        exq.delete(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      n_fail++;
      $display("FAIL unexpected_event ch=%0d kind=%0d: seen at cycle %0d, none expected", ch, kind, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      for (int ch = 0; ch < CH; ch++) begin
        if (clk_out[ch] !== p_out[ch]) begin
          match(ch, clk_out[ch] ? K_OUT_RISE : K_OUT_FALL);
          if (clk_out[ch]) begin
            rise_cnt[ch]++;
            if (!in_burst[ch]) first_rise[ch] = cyc;
            in_burst[ch] = 1'b1;
          end
        end
        if (clk_en[ch] !== p_en[ch]) begin
          match(ch, clk_en[ch] ? K_EN_RISE : K_EN_FALL);
          if (!clk_en[ch]) begin
            en_fall_cyc[ch] = cyc;
            in_burst[ch] = 1'b0;
          end
        end
        if (done[ch] !== 1'b0) begin
          match(ch, K_DONE);
          done_cnt[ch]++;
        end
        if (retrig[ch] !== 1'b0) begin
          match(ch, K_RETRIG);
          retrig_cnt[ch]++;
        end
        p_en[ch]  = clk_en[ch];
        p_out[ch] = clk_out[ch];
      end
      for (int i = exq.size() - 1; i >= 0; i--) begin
        if (exq[i].cyc < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL missing_event ch=%0d kind=%0d: expected at cycle %0d, not seen by cycle %0d",
                   exq[i].ch, exq[i].kind, exq[i].cyc, cyc);
          exq.delete(i);
        end
      end
    end
  end

  // Advance to the next negedge and release strobes held low for two cycles.
  task automatic tick();
    @(negedge clk);
    for (int ch = 0; ch < CH; ch++) begin
      if (f0_rel[ch] > 0) begin
        f0_rel[ch]--;
        if (f0_rel[ch] == 0) begin f0[ch] = 1'b1; f0_cool[ch] = 2; end
      end else if (f0_cool[ch] > 0) f0_cool[ch]--;
      if (c4_rel[ch] > 0) begin
        c4_rel[ch]--;
        if (c4_rel[ch] == 0) begin c4[ch] = 1'b1; c4_cool[ch] = 2; end
      end else if (c4_cool[ch] > 0) c4_cool[ch]--;
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic bit f0_free(int ch);
    return f0[ch] && f0_rel[ch] == 0 && f0_cool[ch] == 0;
  endfunction

  function automatic bit c4_free(int ch);
    return c4[ch] && c4_rel[ch] == 0 && c4_cool[ch] == 0;
  endfunction

  task automatic fall_f0(int ch);
    while (!f0_free(ch)) tick();
    f0[ch] = 1'b0;
    f0_rel[ch] = 2;
    last_f0 = cyc;
    model_f0(ch, cyc);
  endtask

  task automatic fall_c4(int ch);
    while (!c4_free(ch)) tick();
    c4[ch] = 1'b0;
    c4_rel[ch] = 2;
    model_c4(ch, cyc);
  endtask

  task automatic set_cfg(int h, int n, int t);
    half_period = CNT_W'(h);
    pulse_num   = PCNT_W'(n);
    tail_len    = CNT_W'(t);
  endtask

  int base_r, base_d, mc;

  initial begin
    for (int ch = 0; ch < CH; ch++) begin
      m_st[ch] = 0; m_arm[ch] = 0; m_e[ch] = 0; m_end[ch] = 0;
      m_h[ch] = 1; m_n[ch] = 0; m_t[ch] = 0;
      f0_rel[ch] = 0; c4_rel[ch] = 0; f0_cool[ch] = 0; c4_cool[ch] = 0;
      rise_cnt[ch] = 0; done_cnt[ch] = 0; retrig_cnt[ch] = 0;
      first_rise[ch] = 0; en_fall_cyc[ch] = 0; in_burst[ch] = 1'b0;
    end

    // Reset state
    ticks(4);
    chk("rst_clk_en", int'(clk_en), 0);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_retrig", int'(retrig), 0);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    ticks(3);

    // Nominal burst on channel 0
    set_cfg(244, 32, 122);
    fall_f0(0);
    ticks(100);
    fall_c4(0);
    ticks(15494 + 20);
    chk("nominal_pulses", rise_cnt[0], 32);
    chk("nominal_done", done_cnt[0], 1);
    chk("nominal_en_span", en_fall_cyc[0] - first_rise[0], 15494);

    // Zero pulses with a 5-cycle tail on channel 1
    set_cfg(4, 0, 5);
    fall_f0(1);
    ticks(6);
    fall_c4(1);
    mc = cyc;
    ticks(15);
    chk("n0_no_pulses", rise_cnt[1], 0);
    chk("n0_done", done_cnt[1], 1);
    chk("n0_tail_len", en_fall_cyc[1] - (mc + 3), 5);

    // c4 without a prior f0 must leave everything low
    fall_c4(0);
    fall_c4(1);
    ticks(8);
    chk("c4_only_en", int'(clk_en), 0);
    chk("c4_only_out", int'(clk_out), 0);

    // f0 mid-burst: one retrig, burst unchanged
    set_cfg(3, 4, 2);
    base_r = rise_cnt[0];
    fall_f0(0);
    ticks(5);
    fall_c4(0);
    ticks(8);
    fall_f0(0);
    ticks(30);
    chk("retrig_count", retrig_cnt[0], 1);
    chk("retrig_pulses", rise_cnt[0] - base_r, 4);

    // Reset during pulse 10, then a complete burst
    set_cfg(244, 32, 122);
    fall_f0(0);
    ticks(10);
    fall_c4(0);
    mc = cyc;
    while (cyc < mc + 3 + 18 * 244 + 50) tick();
    model_reset(cyc);
    rst_n = 1'b0;
    tick();
    chk("midrst_clk_en", int'(clk_en), 0);
    chk("midrst_clk_out", int'(clk_out), 0);
    chk("midrst_done", int'(done), 0);
    tick();
    rst_n = 1'b1;
    ticks(3);
    base_r = rise_cnt[0];
    base_d = done_cnt[0];
    fall_f0(0);
    ticks(20);
    fall_c4(0);
    ticks(15494 + 20);
    chk("postrst_pulses", rise_cnt[0] - base_r, 32);
    chk("postrst_done", done_cnt[0] - base_d, 1);

    // Staggered channels with config changed between arms
    set_cfg(3, 4, 2);
    base_r = rise_cnt[0];
    base_d = rise_cnt[1];
    fall_f0(0);
    ticks(5);
    set_cfg(7, 2, 3);
    fall_f0(1);
    ticks(3);
    fall_c4(0);
    ticks(4);
    fall_c4(1);
    ticks(60);
    chk("stagger_ch0_pulses", rise_cnt[0] - base_r, 4);
    chk("stagger_ch1_pulses", rise_cnt[1] - base_d, 2);

    // Half-period 0 acts as 1
    set_cfg(0, 3, 2);
    base_r = rise_cnt[1];
    fall_f0(1);
    ticks(5);
    fall_c4(1);
    ticks(20);
    chk("h0_pulses", rise_cnt[1] - base_r, 3);

    // Randomized strobes and small configs on both channels
    for (int it = 0; it < 4000; it++) begin
      tick();
      if (cyc - last_f0 > 4 && $urandom_range(0, 49) == 0)
        set_cfg($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 5));
      for (int ch = 0; ch < CH; ch++) begin
        if (f0_free(ch) && $urandom_range(0, 39) == 0) fall_f0(ch);
        if (c4_free(ch) && $urandom_range(0, 14) == 0) fall_c4(ch);
      end
    end
    ticks(80);

    chk("scoreboard_empty", exq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
